seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver_if.sv | 28 ++
 rtl/seg7_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Load-side bus of the 7-segment scan driver.
//   value    : binary value to display
//   load     : one-cycle capture/convert strobe
//   dp_en    : decimal point enable (sampled with load)
//   dp_pos   : digit index carrying the dp (0 = rightmost)
//   blank_lz : leading-zero blanking enable (sampled with load)
//   busy     : conversion in progress (driver -> application)
interface seg7_scan_driver_if #(
   parameter int VAL_W = 32,
   parameter int DPW   = 3
);
   logic [VAL_W-1:0] value;
   logic             load;
   logic             dp_en;
   logic [DPW-1:0]   dp_pos;
   logic             blank_lz;
   logic             busy;

   modport master (
      output value, load, dp_en, dp_pos, blank_lz,
      input  busy
   );

   modport slave (
      input  value, load, dp_en, dp_pos, blank_lz,
      output busy
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver.
// A loaded binary value is converted to BCD by shift-add-3 (one bit per
// clock). The result is committed atomically to a display register that
// is scanned one digit per SCAN_DIV clocks.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : load-side interface (value/load/dp_en/dp_pos/blank_lz/busy)
//   phyPad : segments, active-low, bit7 = dp, bits6:0 = g..a
//   an     : digit enables, active-low, at most one low bit
//
// state  | meaning
// IDLE   | waiting for load, display register stable
// SHIFT  | one shift-add-3 step per cycle, VAL_W cycles
// COMMIT | copy conversion result to the display register
module seg7_scan_driver #(
   parameter int DIGITS   = 8,
   parameter int VAL_W    = 32,
   parameter int SCAN_DIV = 32000,
   parameter int DPW      = $clog2(DIGITS)
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_driver_if.slave bus,
   output logic [7:0]        phyPad,
   output logic [DIGITS-1:0] an
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(VAL_W);
   localparam int PW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   state_t state, state_nx;

   logic [VAL_W-1:0] val_sr;
   logic [BW-1:0]    bcd;
   logic [BW-1:0]    bcd_adj;
   logic             ovf;
   logic [CW-1:0]    shift_cnt;
   logic             cap_dp_en;
   logic [DPW-1:0]   cap_dp_pos;
   logic             cap_blank;

   logic [BW-1:0]    disp_bcd;
   logic             disp_dp_en;
   logic [DPW-1:0]   disp_dp_pos;
   logic             disp_blank;
   logic             disp_ovf;

   logic [PW-1:0]    presc;
   logic [DPW-1:0]   scan_idx;
   logic             tc;
   logic [3:0]       cur_dig;
   logic             all_zero;
   logic             dp_guard;
   logic             dp_here;
   logic             blank_here;
   logic [7:0]       seg_nx;

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 8'hC0;
         4'd1:    seg_code = 8'hF9;
         4'd2:    seg_code = 8'hA4;
         4'd3:    seg_code = 8'hB0;
         4'd4:    seg_code = 8'h99;
         4'd5:    seg_code = 8'h92;
         4'd6:    seg_code = 8'h82;
         4'd7:    seg_code = 8'hF8;
         4'd8:    seg_code = 8'h80;
         4'd9:    seg_code = 8'h90;
         default: seg_code = 8'hFF;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.load) state_nx = SHIFT;
         SHIFT:   if (shift_cnt == '0) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.busy = (state != IDLE);

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_sr      <= '0;
         bcd         <= '0;
         ovf         <= 1'b0;
         shift_cnt   <= '0;
         cap_dp_en   <= 1'b0;
         cap_dp_pos  <= '0;
         cap_blank   <= 1'b1;
         disp_bcd    <= '0;
         disp_dp_en  <= 1'b0;
         disp_dp_pos <= '0;
         disp_blank  <= 1'b1;
         disp_ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load) begin
                  val_sr     <= bus.value;
                  bcd        <= '0;
                  ovf        <= 1'b0;
                  shift_cnt  <= CW'(VAL_W - 1);
                  cap_dp_en  <= bus.dp_en;
                  cap_dp_pos <= bus.dp_pos;
                  cap_blank  <= bus.blank_lz;
               end
            end
            SHIFT: begin
               bcd       <= {bcd_adj[BW-2:0], val_sr[VAL_W-1]};
               val_sr    <= {val_sr[VAL_W-2:0], 1'b0};
               shift_cnt <= shift_cnt - 1'b1;
               // a bit leaving the top nibble means the value needs more digits
               if (bcd_adj[BW-1]) ovf <= 1'b1;
            end
            COMMIT: begin
               disp_bcd    <= bcd;
               disp_dp_en  <= cap_dp_en;
               disp_dp_pos <= cap_dp_pos;
               disp_blank  <= cap_blank;
               disp_ovf    <= ovf;
            end
            default: ;
         endcase
      end
   end

   assign tc      = (presc == PW'(SCAN_DIV - 1));
   assign cur_dig = disp_bcd[{scan_idx, 2'b00} +: 4];

   always_comb begin
      all_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(scan_idx) && disp_bcd[4*i +: 4] != 4'd0) all_zero = 1'b0;
      end
   end

   // digits at or right of the dp position are never blanked
   assign dp_guard   = disp_dp_en && (scan_idx <= disp_dp_pos);
   assign dp_here    = disp_dp_en && (scan_idx == disp_dp_pos);
   assign blank_here = disp_blank && (scan_idx != '0) && all_zero && !dp_guard;

   always_comb begin
      seg_nx = seg_code(cur_dig);
      if (dp_here) seg_nx[7] = 1'b0;
      if (blank_here) seg_nx = 8'hFF;
      if (disp_ovf)   seg_nx = 8'hBF;
   end

   // scan_idx names the digit shown at the next terminal count, so the
   // first dwell after reset lands on digit 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         scan_idx <= '0;
         phyPad   <= 8'hFF;
         an       <= '1;
      end else begin
         if (tc) begin
            presc  <= '0;
            phyPad <= seg_nx;
            an     <= ~(DIGITS'(1) << scan_idx);
            if (scan_idx == DPW'(DIGITS - 1)) scan_idx <= '0;
            else                              scan_idx <= scan_idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   logic       clk;
   logic       rst_n;
   logic [7:0] phyPad;
   logic [3:0] an;

   int n_checks = 0;
   int n_err    = 0;

   seg7_scan_driver_if #(.VAL_W(16), .DPW(2)) bus ();

   seg7_scan_driver #(
      .DIGITS(4),
      .VAL_W(16),
      .SCAN_DIV(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .phyPad(phyPad),
      .an    (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] val;
      logic        dpe;
      logic [1:0]  dpp;
      logic        blz;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic dpe, input logic [1:0] dpp,
                          input logic blz);
      @(negedge clk);
      bus.value    = v;
      bus.dp_en    = dpe;
      bus.dp_pos   = dpp;
      bus.blank_lz = blz;
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (bus.busy && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic check_disp(input string name, input logic [31:0] exp);
      bit ok;
      repeat (5) @(negedge clk);
      for (int i = 3; i >= 0; i--) begin
         ok = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (an == ~(4'b0001 << i)) begin
               ok = 1;
               break;
            end
         end
         if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL %s scan timeout digit %0d: an=%b", name, i, an);
         end else begin
            check($sformatf("%s d%0d", name, i), {24'h0, phyPad}, {24'h0, exp[8*i +: 8]});
         end
      end
   endtask

   // called at a negedge with rst_n low
   task automatic scan_after_reset(input string name);
      logic [3:0] exp_an;
      rst_n = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(negedge clk);
         check($sformatf("%s pre-tc an c%0d", name, e), {28'h0, an}, 32'hF);
      end
      check({name, " busy"}, {31'h0, bus.busy}, 32'h0);
      for (int s = 0; s < 8; s++) begin
         exp_an = ~(4'b0001 << (s % 4));
         @(negedge clk);
         check($sformatf("%s an step%0d", name, s), {28'h0, an}, {28'h0, exp_an});
         check($sformatf("%s seg step%0d", name, s), {24'h0, phyPad},
               (s % 4 == 0) ? 32'hC0 : 32'hFF);
         repeat (3) @(negedge clk);
         check($sformatf("%s an hold%0d", name, s), {28'h0, an}, {28'h0, exp_an});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;

      vecs[0]  = '{"v7_dp2_blz",    16'd7,     1'b1, 2'd2, 1'b1, 32'hFF40C0F8};
      vecs[1]  = '{"ovf_10000",     16'd10000, 1'b0, 2'd0, 1'b0, 32'hBFBFBFBF};
      vecs[2]  = '{"max_9999",      16'd9999,  1'b0, 2'd0, 1'b0, 32'h90909090};
      vecs[3]  = '{"zero_blz",      16'd0,     1'b0, 2'd0, 1'b1, 32'hFFFFFFC0};
      vecs[4]  = '{"zero_noblz",    16'd0,     1'b0, 2'd0, 1'b0, 32'hC0C0C0C0};
      vecs[5]  = '{"v105_blz",      16'd105,   1'b0, 2'd0, 1'b1, 32'hFFF9C092};
      vecs[6]  = '{"v5_dp0_blz",    16'd5,     1'b1, 2'd0, 1'b1, 32'hFFFFFF12};
      vecs[7]  = '{"ovf_65535",     16'd65535, 1'b0, 2'd0, 1'b1, 32'hBFBFBFBF};
      vecs[8]  = '{"v50_dp3",       16'd50,    1'b1, 2'd3, 1'b0, 32'h40C092C0};
      vecs[9]  = '{"v50_dp1_blz",   16'd50,    1'b1, 2'd1, 1'b1, 32'hFFFF12C0};
      vecs[10] = '{"ovf_dp_blz",    16'd10000, 1'b1, 2'd0, 1'b1, 32'hBFBFBFBF};

      rst_n        = 1'b0;
      bus.value    = '0;
      bus.load     = 1'b0;
      bus.dp_en    = 1'b0;
      bus.dp_pos   = '0;
      bus.blank_lz = 1'b0;
      repeat (2) @(negedge clk);
      check("rst an",     {28'h0, an},       32'hF);
      check("rst phyPad", {24'h0, phyPad},   32'hFF);
      check("rst busy",   {31'h0, bus.busy}, 32'h0);
      scan_after_reset("reset");

      do_load(16'd1234, 1'b0, 2'd0, 1'b0);
      wait_idle(cnt);
      check("busy_len 1234", cnt, 17);
      check_disp("v1234", 32'hF9A4B099);

      for (int k = 0; k < 11; k++) begin
         do_load(vecs[k].val, vecs[k].dpe, vecs[k].dpp, vecs[k].blz);
         wait_idle(cnt);
         check({vecs[k].name, " busy_len"}, cnt, 17);
         check_disp(vecs[k].name, vecs[k].exp);
      end

      // second load one cycle into a conversion must be ignored
      @(negedge clk);
      bus.value    = 16'd42;
      bus.dp_en    = 1'b0;
      bus.dp_pos   = 2'd0;
      bus.blank_lz = 1'b1;
      bus.load     = 1'b1;
      @(negedge clk);
      check("ign busy at 2nd load", {31'h0, bus.busy}, 32'h1);
      bus.value    = 16'd99;
      bus.blank_lz = 1'b0;
      @(negedge clk);
      bus.load     = 1'b0;
      wait_idle(cnt);
      check("ign busy_len", cnt + 1, 17);
      check_disp("ign_v42", 32'hFFFF99A4);

      // reset in the middle of a conversion
      do_load(16'd5678, 1'b0, 2'd0, 1'b0);
      repeat (7) @(negedge clk);
      check("mid busy before rst", {31'h0, bus.busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid rst busy",   {31'h0, bus.busy}, 32'h0);
      check("mid rst an",     {28'h0, an},       32'hF);
      check("mid rst phyPad", {24'h0, phyPad},   32'hFF);
      @(negedge clk);
      scan_after_reset("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
